spi_slave_reg_ctrl: RTL and testbench
=====================================

Name: spi_slave_reg_ctrl

Overview:
- Byte-level command/register controller that sits directly downstream of the SPI slave byte engine, in the i_Clk domain.
- Consumes received bytes (RX_DV/RX_Byte) and feeds reply bytes back to the slave (TX_DV/TX_Byte).
- Frame protocol: the first byte after CS_n falls is a command (R/W bit plus start address). Following bytes write, or read back, an internal register bank with address auto-increment.
- The register bank is exposed flat to the rest of the design.

Parameters:
- NUM_REGS, 16, number of 8-bit registers implemented (1..128).
- ADDR_W, 7, command address field width; fixed by protocol, do not override.
- CS_END_DLY, 6, i_Clk cycles after the synchronised CS_n rise before the frame is closed.
- STATUS_BYTE, 8'hA5, byte loaded for MISO when no read data is pending.

Ports:
- i_Clk  in  1  system clock; must be at least 4x the SPI clock.
- i_Rst  in  1  synchronous, active-high reset.
- i_RX_DV  in  1  one-cycle pulse: received byte valid.
- i_RX_Byte  in  8  received byte.
- i_SPI_CS_n  in  1  raw chip select, asynchronous to i_Clk.
- o_TX_DV  out  1  one-cycle pulse: load o_TX_Byte into the slave.
- o_TX_Byte  out  8  byte for the slave to shift out on MISO.
- o_Regs  out  NUM_REGS*8  register bank, reg k at bits [8k+7:8k].
- o_Wr_Strobe  out  1  one-cycle pulse on each register write.
- o_Wr_Addr  out  7  address of that write.
- o_Err_Cnt  out  8  out-of-range access counter (see Optional Feature).

Behaviour:
- Reset (i_Rst=1 at posedge i_Clk):
  - All registers = 0, o_TX_DV=0, o_TX_Byte=8'h00, o_Wr_Strobe=0, o_Wr_Addr=0, o_Err_Cnt=0.
  - State IDLE, address pointer = 0.
  - Reset mid-frame abandons the frame; no write completes after reset.
- CS sync:
  - i_SPI_CS_n passes through a 3-flop synchroniser, then edge detect.
  - A fall starts a frame. A rise starts a CS_END_DLY countdown.
- State CMD (entered from IDLE on CS fall). On i_RX_DV in cycle N, the command byte decodes as:
  - bit7: 1=write, 0=read.
  - bits[6:0]: start address.
  - Read: in cycle N+1, o_TX_DV=1 and o_TX_Byte=reg[addr]; pointer=addr+1; state READ.
  - Write: in cycle N+1, o_TX_DV=1 and o_TX_Byte=STATUS_BYTE; pointer=addr; state WRITE.
- State READ: on each i_RX_DV in cycle N, the received byte is ignored. In cycle N+1, o_TX_DV=1 with reg[pointer], then pointer++.
- State WRITE: on each i_RX_DV in cycle N, in cycle N+1:
  - reg[pointer]=i_RX_Byte, visible on o_Regs in cycle N+1.
  - o_Wr_Strobe=1 and o_Wr_Addr=pointer.
  - pointer++.
  - No o_TX_DV.
- Pointer is 7 bits and wraps 127->0.
- Out-of-range address (pointer >= NUM_REGS):
  - A write is dropped, with no strobe.
  - A read returns 8'h00.
- Frame end:
  - i_RX_DV arriving during the countdown is processed normally in the current state.
  - When the count expires, state -> IDLE. In the same cycle, o_TX_DV=1 with STATUS_BYTE, so the next frame's first MISO byte is status.
  - A CS fall during the countdown cancels it and restarts in CMD.
- Simultaneous events:
  - i_RX_DV coinciding with countdown expiry is processed first, then the state goes IDLE. The STATUS_BYTE load wins on o_TX_Byte.
  - i_RX_DV in IDLE is ignored.
- o_TX_DV and o_Wr_Strobe never assert for more than one cycle per cause.

Optional Feature:
- Macro SPI_REG_CTRL_ERR_CNT_EN.
- Defined: o_Err_Cnt increments by one per out-of-range read or write byte. It saturates at 8'hFF and clears only on reset.
- Undefined: o_Err_Cnt is a constant 8'h00 and no counter logic is built. Out-of-range behaviour is otherwise identical.

Decomposition:
- Package spi_reg_pkg:
  - State enum {IDLE, CMD, READ, WRITE}.
  - CMD_WR_BIT=7.
  - CMD_ADDR_MSB=6.
  - Default STATUS_BYTE.
- Sub-module spi_cs_sync: 3-flop synchroniser plus registered rise/fall pulses. It is reused by other SPI-side blocks.

Test Plan:
- Reset: assert i_Rst for 2 cycles -> all outputs 0, o_Regs all 0, state IDLE.
- Write burst: CS low, bytes 8'h82, 8'h11, 8'h22, CS high -> reg2=8'h11, reg3=8'h22. o_Wr_Strobe pulses with addr 2 then 3. After CS_END_DLY, a TX pulse with 8'hA5.
- Read burst: preload reg3=8'h5C, reg4=8'h7E. Send 8'h03 then two dummy bytes -> TX pulses carry 8'h5C one cycle after the command RX_DV, and 8'h7E after the next.
- Out-of-range access, NUM_REGS=16:
  - Write 8'h8F followed by 8'hAA, 8'hBB -> reg15=8'hAA. Addr 16 is dropped with no strobe. o_Err_Cnt=1 (macro on) or 0 (macro off).
  - Read at 8'h7F -> returns 8'h00, pointer wraps to 0, and the next read returns reg0.
- Late RX_DV: pulse i_RX_DV 3 cycles after the synchronised CS rise in WRITE -> write still lands, then IDLE. If RX_DV coincides with expiry, the write lands and TX carries 8'hA5.
- Reset mid-frame: i_Rst during WRITE between bytes -> no further writes. After release, a CS fall restarts cleanly in CMD.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// -----------------------------------------------------------------------------
// spi_reg_pkg
// Shared types and constants for the SPI register controller.
//   state_t          : frame FSM states
//   CMD_WR_BIT       : command byte R/W flag position (1 = write)
//   CMD_ADDR_MSB     : top bit of the command start-address field
//   STATUS_BYTE_DFLT : default byte presented on MISO when no read data
// -----------------------------------------------------------------------------
package spi_reg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } state_t;

    localparam int         CMD_WR_BIT       = 7;
    localparam int         CMD_ADDR_MSB     = 6;
    localparam logic [7:0] STATUS_BYTE_DFLT = 8'hA5;

endpackage

// File: rtl/spi_cs_sync.sv
// -----------------------------------------------------------------------------
// spi_cs_sync
// Brings a raw, asynchronous SPI chip select into the i_Clk domain through a
// 3-flop synchroniser and produces registered one-cycle edge pulses.
// Ports:
//   i_Clk   : system clock
//   i_Rst   : synchronous active-high reset (clears the edge pulses)
//   i_CS_n  : raw chip select, asynchronous
//   o_CS_n  : synchronised chip-select level
//   o_Fall  : one-cycle pulse, aligned with o_CS_n going low
//   o_Rise  : one-cycle pulse, aligned with o_CS_n going high
// -----------------------------------------------------------------------------
module spi_cs_sync (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_CS_n,
    output logic o_CS_n,
    output logic o_Fall,
    output logic o_Rise
);

    logic [2:0] r_sync;
    logic       r_fall;
    logic       r_rise;

    // The synchroniser chain is deliberately not reset: it keeps tracking the
    // pin through reset, so a reset taken while CS is held low does not
    // fabricate a falling edge (and thus a new frame) on release.
    always_ff @(posedge i_Clk) begin
        r_sync <= {r_sync[1:0], i_CS_n};
    end

    // Edge is taken between flops 2 and 3 so the pulse lines up with o_CS_n.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_fall <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_fall <=  r_sync[2] & ~r_sync[1];
            r_rise <= ~r_sync[2] &  r_sync[1];
        end
    end

    assign o_CS_n = r_sync[2];
    assign o_Fall = r_fall;
    assign o_Rise = r_rise;

endmodule

// File: rtl/spi_slave_reg_ctrl.sv
// -----------------------------------------------------------------------------
// spi_slave_reg_ctrl
// Command/register controller behind an SPI slave byte engine. First byte of a
// frame is a command {R/W, start address}; following bytes write or read back
// an 8-bit register bank with address auto-increment (7-bit pointer, wraps).
// Optional feature: define SPI_REG_CTRL_ERR_CNT_EN to build a saturating
// counter of out-of-range read/write bytes on o_Err_Cnt (else constant 0).
// Ports:
//   i_Clk, i_Rst          : clock, synchronous active-high reset
//   i_RX_DV, i_RX_Byte    : received byte strobe/data from the slave
//   i_SPI_CS_n            : raw chip select (asynchronous)
//   o_TX_DV, o_TX_Byte    : reply byte load strobe/data to the slave
//   o_Regs                : flat register bank, reg k at [8k+7:8k]
//   o_Wr_Strobe, o_Wr_Addr: one-cycle write notification and its address
//   o_Err_Cnt             : out-of-range access counter
// -----------------------------------------------------------------------------
module spi_slave_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int         NUM_REGS    = 16,
    parameter int         ADDR_W      = 7,
    parameter int         CS_END_DLY  = 6,
    parameter logic [7:0] STATUS_BYTE = STATUS_BYTE_DFLT
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_RX_DV,
    input  logic [7:0]            i_RX_Byte,
    input  logic                  i_SPI_CS_n,
    output logic                  o_TX_DV,
    output logic [7:0]            o_TX_Byte,
    output logic [NUM_REGS*8-1:0] o_Regs,
    output logic                  o_Wr_Strobe,
    output logic [ADDR_W-1:0]     o_Wr_Addr,
    output logic [7:0]            o_Err_Cnt
);

    localparam int CNT_W = (CS_END_DLY > 1) ? $clog2(CS_END_DLY) : 1;

    logic                     w_cs_n, w_cs_fall, w_cs_rise;
    state_t                   r_state, w_state_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_cnt_act, w_expire;
    logic [ADDR_W-1:0]        r_ptr, w_ptr_nxt, w_acc_addr, w_cmd_addr;
    logic                     w_cmd_wr, w_acc_oor;
    logic [7:0]               w_rd_data;
    logic [NUM_REGS-1:0][7:0] r_regs;
    logic                     w_tx_dv, w_wr_en;
    logic [7:0]               w_tx_byte;
    logic                     r_tx_dv, r_wr_strobe;
    logic [7:0]               r_tx_byte;
    logic [ADDR_W-1:0]        r_wr_addr;

    spi_cs_sync u_cs_sync (
        .i_Clk  (i_Clk),
        .i_Rst  (i_Rst),
        .i_CS_n (i_SPI_CS_n),
        .o_CS_n (w_cs_n),
        .o_Fall (w_cs_fall),
        .o_Rise (w_cs_rise)
    );

    // Frame-end countdown: loaded on the synchronised rise, expires exactly
    // CS_END_DLY cycles later; a new fall cancels it.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_cnt_act <= 1'b0;
            r_cnt     <= '0;
        end else if (w_cs_fall) begin
            r_cnt_act <= 1'b0;
        end else if (w_cs_rise) begin
            r_cnt_act <= 1'b1;
            r_cnt     <= CNT_W'(CS_END_DLY - 1);
        end else if (w_expire) begin
            r_cnt_act <= 1'b0;
        end else if (r_cnt_act && w_cs_n && (r_cnt != '0)) begin
            r_cnt     <= r_cnt - 1'b1;
        end
    end

    assign w_expire = r_cnt_act && w_cs_n && (r_cnt == '0);

    // Address under access this cycle: the command's start address in CMD,
    // otherwise the running pointer.
    assign w_cmd_wr   = i_RX_Byte[CMD_WR_BIT];
    assign w_cmd_addr = i_RX_Byte[CMD_ADDR_MSB:0];
    assign w_acc_addr = (r_state == CMD) ? w_cmd_addr : r_ptr;
    assign w_acc_oor  = (int'(w_acc_addr) >= NUM_REGS);

    // Out-of-range addresses match no entry and read back as 0.
    always_comb begin
        w_rd_data = 8'h00;
        for (int k = 0; k < NUM_REGS; k++)
            if (w_acc_addr == ADDR_W'(k)) w_rd_data = r_regs[k];
    end

    // FSM: state register
    always_ff @(posedge i_Clk) begin
        if (i_Rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // FSM: next state. A byte on the expiry cycle is still processed by the
    // output logic; the state itself goes IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (w_cs_fall)
            w_state_nxt = CMD;
        else if (w_expire)
            w_state_nxt = IDLE;
        else if (i_RX_DV && (r_state == CMD))
            w_state_nxt = w_cmd_wr ? WRITE : READ;
    end

    // FSM: outputs (next values for the registered outputs and pointer)
    always_comb begin
        w_tx_dv   = 1'b0;
        w_tx_byte = r_tx_byte;
        w_wr_en   = 1'b0;
        w_ptr_nxt = r_ptr;
        if (i_RX_DV) begin
            unique case (r_state)
                CMD: begin
                    w_tx_dv = 1'b1;
                    if (w_cmd_wr) begin
                        w_tx_byte = STATUS_BYTE;
                        w_ptr_nxt = w_cmd_addr;
                    end else begin
                        w_tx_byte = w_rd_data;
                        w_ptr_nxt = w_cmd_addr + 1'b1;
                    end
                end
                READ: begin
                    w_tx_dv   = 1'b1;
                    w_tx_byte = w_rd_data;
                    w_ptr_nxt = r_ptr + 1'b1;
                end
                WRITE: begin
                    w_wr_en   = ~w_acc_oor;
                    w_ptr_nxt = r_ptr + 1'b1;
                end
                default: ;
            endcase
        end
        // Status preload for the next frame wins over any read data.
        if (w_expire) begin
            w_tx_dv   = 1'b1;
            w_tx_byte = STATUS_BYTE;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_regs      <= '0;
            r_ptr       <= '0;
            r_tx_dv     <= 1'b0;
            r_tx_byte   <= 8'h00;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_tx_dv     <= w_tx_dv;
            r_tx_byte   <= w_tx_byte;
            r_wr_strobe <= w_wr_en;
            if (w_wr_en) r_wr_addr <= r_ptr;
            for (int k = 0; k < NUM_REGS; k++)
                if (w_wr_en && (r_ptr == ADDR_W'(k))) r_regs[k] <= i_RX_Byte;
        end
    end

`ifdef SPI_REG_CTRL_ERR_CNT_EN
    logic       w_oor_hit;
    logic [7:0] r_err_cnt;

    // Counts data bytes that touch a missing register; a write command alone
    // carries no data and is not counted.
    assign w_oor_hit = i_RX_DV && w_acc_oor &&
                       ((r_state == READ) || (r_state == WRITE) ||
                        ((r_state == CMD) && !w_cmd_wr));

    always_ff @(posedge i_Clk) begin
        if (i_Rst)                               r_err_cnt <= 8'h00;
        else if (w_oor_hit && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'h01;
    end

    assign o_Err_Cnt = r_err_cnt;
`else
    assign o_Err_Cnt = 8'h00;
`endif

    assign o_Regs      = r_regs;
    assign o_TX_DV     = r_tx_dv;
    assign o_TX_Byte   = r_tx_byte;
    assign o_Wr_Strobe = r_wr_strobe;
    assign o_Wr_Addr   = r_wr_addr;

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_reg_ctrl
// Directed self-checking bench for spi_slave_reg_ctrl (NUM_REGS=16,
// CS_END_DLY=6). Inputs are driven and outputs sampled on the falling edge.
// Expected o_Err_Cnt follows SPI_REG_CTRL_ERR_CNT_EN.
// -----------------------------------------------------------------------------
module tb_spi_slave_reg_ctrl;

    localparam int NUM_REGS = 16;

`ifdef SPI_REG_CTRL_ERR_CNT_EN
    localparam logic [7:0] ERR1 = 8'd1;
    localparam logic [7:0] ERR2 = 8'd2;
`else
    localparam logic [7:0] ERR1 = 8'd0;
    localparam logic [7:0] ERR2 = 8'd0;
`endif

    logic                  i_Clk = 1'b0;
    logic                  i_Rst;
    logic                  i_RX_DV;
    logic [7:0]            i_RX_Byte;
    logic                  i_SPI_CS_n;
    logic                  o_TX_DV;
    logic [7:0]            o_TX_Byte;
    logic [NUM_REGS*8-1:0] o_Regs;
    logic                  o_Wr_Strobe;
    logic [6:0]            o_Wr_Addr;
    logic [7:0]            o_Err_Cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_Clk = ~i_Clk;

    spi_slave_reg_ctrl #(.NUM_REGS(NUM_REGS), .CS_END_DLY(6)) dut (
        .i_Clk       (i_Clk),
        .i_Rst       (i_Rst),
        .i_RX_DV     (i_RX_DV),
        .i_RX_Byte   (i_RX_Byte),
        .i_SPI_CS_n  (i_SPI_CS_n),
        .o_TX_DV     (o_TX_DV),
        .o_TX_Byte   (o_TX_Byte),
        .o_Regs      (o_Regs),
        .o_Wr_Strobe (o_Wr_Strobe),
        .o_Wr_Addr   (o_Wr_Addr),
        .o_Err_Cnt   (o_Err_Cnt)
    );

    function automatic logic [7:0] rg(input int k);
        return o_Regs[k*8 +: 8];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    // Called on a falling edge; returns one cycle later with the response
    // to the byte visible.
    task automatic send(input logic [7:0] b);
        i_RX_DV   = 1'b1;
        i_RX_Byte = b;
        @(negedge i_Clk);
        i_RX_DV   = 1'b0;
    endtask

    task automatic cs_fall();
        i_SPI_CS_n = 1'b0;
        idle(5);
    endtask

    // Raise CS and expect the status preload 10 falling edges later:
    // 3 sync flops + 6 countdown cycles + 1 output register.
    task automatic close_frame(input string tag);
        int cyc;
        cyc = 0;
        i_SPI_CS_n = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge i_Clk);
            if (o_TX_DV) begin
                cyc = i;
                break;
            end
        end
        chk({tag, "_lat"}, cyc, 10);
        chk({tag, "_stat"}, o_TX_Byte, 8'hA5);
        @(negedge i_Clk);
        chk({tag, "_pulse"}, o_TX_DV, 1'b0);
    endtask

    initial begin
        i_Rst      = 1'b1;
        i_RX_DV    = 1'b0;
        i_RX_Byte  = 8'h00;
        i_SPI_CS_n = 1'b1;

        // Reset: held long enough to flush the CS synchroniser
        idle(4);
        chk("rst_txdv",   o_TX_DV, 1'b0);
        chk("rst_txbyte", o_TX_Byte, 8'h00);
        chk("rst_strb",   o_Wr_Strobe, 1'b0);
        chk("rst_waddr",  o_Wr_Addr, 7'd0);
        chk("rst_err",    o_Err_Cnt, 8'h00);
        chk("rst_regs",   o_Regs, '0);
        i_Rst = 1'b0;
        idle(3);
        chk("idle_txdv", o_TX_DV, 1'b0);

        // Write burst 0x82, 0x11, 0x22
        cs_fall();
        send(8'h82);
        chk("wcmd_txdv", o_TX_DV, 1'b1);
        chk("wcmd_stat", o_TX_Byte, 8'hA5);
        chk("wcmd_nostrb", o_Wr_Strobe, 1'b0);
        idle(1);
        chk("wcmd_txpulse", o_TX_DV, 1'b0);
        send(8'h11);
        chk("w2_strb", o_Wr_Strobe, 1'b1);
        chk("w2_addr", o_Wr_Addr, 7'd2);
        chk("w2_reg",  rg(2), 8'h11);
        chk("w2_notx", o_TX_DV, 1'b0);
        idle(1);
        chk("w2_strbpulse", o_Wr_Strobe, 1'b0);
        send(8'h22);
        chk("w3_strb", o_Wr_Strobe, 1'b1);
        chk("w3_addr", o_Wr_Addr, 7'd3);
        chk("w3_reg",  rg(3), 8'h22);
        close_frame("wburst");

        // Preload reg3/reg4 and reg0, then read burst at 3
        cs_fall();
        send(8'h83); idle(2);
        send(8'h5C); idle(2);
        send(8'h7E);
        close_frame("pre34");
        cs_fall();
        send(8'h80); idle(2);
        send(8'h3C);
        close_frame("pre0");
        cs_fall();
        send(8'h03);
        chk("r3_txdv", o_TX_DV, 1'b1);
        chk("r3_data", o_TX_Byte, 8'h5C);
        idle(2);
        send(8'h00);
        chk("r4_txdv", o_TX_DV, 1'b1);
        chk("r4_data", o_TX_Byte, 8'h7E);
        chk("r4_nostrb", o_Wr_Strobe, 1'b0);
        chk("r_reg3", rg(3), 8'h5C);
        close_frame("rburst");

        // Out-of-range write: 15 lands, 16 dropped
        cs_fall();
        send(8'h8F); idle(2);
        send(8'hAA);
        chk("oor_w15_strb", o_Wr_Strobe, 1'b1);
        chk("oor_w15_addr", o_Wr_Addr, 7'd15);
        chk("oor_w15_reg",  rg(15), 8'hAA);
        idle(2);
        send(8'hBB);
        chk("oor_w16_nostrb", o_Wr_Strobe, 1'b0);
        chk("oor_w16_addr",   o_Wr_Addr, 7'd15);
        chk("oor_w_err",      o_Err_Cnt, ERR1);
        close_frame("oorw");

        // Out-of-range read at 127, pointer wraps to 0
        cs_fall();
        send(8'h7F);
        chk("oor_r127_txdv", o_TX_DV, 1'b1);
        chk("oor_r127_data", o_TX_Byte, 8'h00);
        chk("oor_r_err",     o_Err_Cnt, ERR2);
        idle(2);
        send(8'h00);
        chk("wrap_r0_data", o_TX_Byte, 8'h3C);
        close_frame("oorr");

        // Late byte 3 cycles after the synchronised rise
        cs_fall();
        send(8'h85); idle(2);
        send(8'h01);
        chk("late_reg5", rg(5), 8'h01);
        i_SPI_CS_n = 1'b1;
        idle(6);
        send(8'h66);
        chk("late_strb", o_Wr_Strobe, 1'b1);
        chk("late_addr", o_Wr_Addr, 7'd6);
        chk("late_reg6", rg(6), 8'h66);
        idle(3);
        chk("late_stat_dv", o_TX_DV, 1'b1);
        chk("late_stat",    o_TX_Byte, 8'hA5);
        idle(1);
        chk("late_stat_pulse", o_TX_DV, 1'b0);

        // Byte coinciding with countdown expiry
        cs_fall();
        send(8'h87);
        i_SPI_CS_n = 1'b1;
        idle(9);
        send(8'h77);
        chk("coin_strb", o_Wr_Strobe, 1'b1);
        chk("coin_addr", o_Wr_Addr, 7'd7);
        chk("coin_reg7", rg(7), 8'h77);
        chk("coin_txdv", o_TX_DV, 1'b1);
        chk("coin_stat", o_TX_Byte, 8'hA5);
        idle(2);
        send(8'hF0);
        chk("idle_rx_nostrb", o_Wr_Strobe, 1'b0);
        chk("idle_rx_notx",   o_TX_DV, 1'b0);
        chk("idle_rx_reg8",   rg(8), 8'h00);

        // Reset mid-frame in WRITE
        cs_fall();
        send(8'h89); idle(2);
        send(8'h99);
        chk("mid_reg9", rg(9), 8'h99);
        idle(2);
        i_Rst = 1'b1;
        idle(2);
        i_Rst = 1'b0;
        chk("mid_rst_regs", o_Regs, '0);
        idle(1);
        send(8'h55);
        chk("mid_nostrb", o_Wr_Strobe, 1'b0);
        chk("mid_notx",   o_TX_DV, 1'b0);
        chk("mid_regs",   o_Regs, '0);
        i_SPI_CS_n = 1'b1;
        idle(15);
        cs_fall();
        send(8'h8A);
        chk("restart_txdv", o_TX_DV, 1'b1);
        chk("restart_stat", o_TX_Byte, 8'hA5);
        idle(2);
        send(8'h44);
        chk("restart_strb", o_Wr_Strobe, 1'b1);
        chk("restart_addr", o_Wr_Addr, 7'd10);
        chk("restart_reg",  rg(10), 8'h44);
        close_frame("restart");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
